pwm_channel_bank: RTL and testbench
===================================

# pwm_channel_bank

Parametrised multi-channel PWM core with an on-chip byte-addressed register file, succeeding the single-register PWM stage of the IO expander. It receives already-deserialised SPI bytes (synchronised into the CLK domain), decodes an address-then-data protocol with auto-increment, and drives NumOfPWMOutputs independent PWM outputs. All channels share one programmable period and prescaler. Duty and period updates are double-buffered and take effect only at a period boundary, so no output ever glitches.

## Interface
- NumOfPWMOutputs, 4, number of PWM channels; legal range 1–8.
- CLK  in  1  system clock; all logic is on its rising edge.
- _RST  in  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- _CS  in  1  SPI chip select, already synchronised to CLK; low means a transaction is in progress.
- RXValid  in  1  one-CLK pulse per byte received from the SPI slave.
- RXByte  in  8  received byte; valid while RXValid=1.
- TXByte  out  8  registered readback of the register at the address pointer; goes to the SPI slave TX line.
- PWMOutputs  out  NumOfPWMOutputs  registered PWM outputs.
- PeriodWrap  out  1  one-CLK pulse on each counter wrap.

## Operation
- Register map (8-bit):
  - 0 CTRL: bit0 = global enable (EN), bit1 = invert (INV); other bits read as 0.
  - 1 PERIOD: shadowed.
  - 2 PRESCALE.
  - 3 CHEN: channel mask, bit i enables channel i; bits at or above NumOfPWMOutputs read as 0.
  - 4 to 4+N-1 DUTY[i]: shadowed.
- Unmapped addresses: writes are ignored and reads return 0x00.
- Reset values:
  - CTRL = 0x00, PERIOD = 0xFF, PRESCALE = 0x00, CHEN = all N bits set, DUTY = 0x00 (pending and active).
  - Pointer = 0, counter = 0, prescale count = 0.
  - TXByte = 0x00, PWMOutputs = 0, PeriodWrap = 0.
- Protocol FSM, two states:
  - ADDR: entered on reset and on every cycle with _CS=1. RXValid while _CS=1 is ignored. RXValid with _CS=0 loads the pointer from RXByte, writes nothing, and moves to DATA.
  - DATA: RXValid with _CS=0 writes RXByte to reg[pointer] and increments the pointer modulo 256 (0xFF wraps to 0x00). _CS=1 returns to ADDR.
- Write semantics:
  - CTRL, PRESCALE and CHEN take effect in the cycle after the write.
  - PERIOD and DUTY writes go to pending registers; readback returns the pending value.
- Prescaler: a tick occurs when the prescale count equals PRESCALE; the count then returns to 0, otherwise it increments. The tick period is PRESCALE+1 CLK cycles.
- Counter, with EN=1, on each tick:
  - If counter == PERIOD_active: counter goes to 0, all pending values copy to active, and PeriodWrap pulses.
  - Otherwise the counter increments.
- EN=0: counter and prescale count are held at 0, active values copy from pending every cycle, and PeriodWrap stays 0.
- Output i = EN & CHEN[i] & ((counter < DUTY_active[i]) ^ INV).
  - A disabled or masked channel drives 0 regardless of INV.
  - DUTY = 0 gives constant low; DUTY > PERIOD gives constant high (both before INV).
- Width rules: comparisons are 8-bit unsigned. The counter never exceeds PERIOD_active because active values only change at a wrap.

## Timing
- Register write: RXValid at edge k updates the register at k+1. The pointer increments at k+1, and TXByte reflects the new pointer at k+2.
- TXByte is always registered; it is valid one cycle after any pointer or register change.
- PWMOutputs lag the counter by one CLK.
- Wrap and shadow load happen on the same edge. PeriodWrap is high for exactly that one cycle.
- A DUTY or PERIOD write on the same edge as a wrap does not reach the active register until the next wrap.
- _CS rising on the same edge as RXValid: the byte is still processed, then the FSM returns to ADDR.
- _RST low overrides everything, including an RXValid in the same cycle.

## Test plan
- Reset: hold _RST low 2 cycles with RXValid=1 -> all outputs 0, CTRL readback 0x00, PERIOD readback 0xFF, CHEN readback 0x0F for N=4.
- Burst write: _CS low; bytes 0x01,0x09,0x00,0x0F,0x05 -> PERIOD=9, PRESCALE=0, CHEN=0x0F, DUTY0=5, pointer ends at 5. Then write CTRL=0x01 -> channel 0 high 5 of every 10 CLK and PeriodWrap every 10 CLK; other channels constant 0.
- Shadowing: mid-period, write DUTY0=0x02 -> duty stays 5 until the next PeriodWrap, then becomes 2. No output pulse is shorter than 2 or longer than 5 cycles.
- Extremes and invert: DUTY1=0, DUTY2=0xFF with PERIOD=9 -> ch1 constant 0, ch2 constant 1. Set CTRL=0x03 -> ch1 constant 1, ch2 constant 0. Clear CHEN bit2 -> ch2 constant 0.
- Prescale: PRESCALE=3, PERIOD=4 -> PeriodWrap every 20 CLK.
- Protocol edges: RXValid while _CS high -> no change. Address 0xFF followed by two data bytes -> first byte ignored (unmapped), second byte written to CTRL. Address 0x20 -> TXByte reads 0x00.

Source files
------------

// File: rtl/pwm_channel_bank.sv
// pwm_channel_bank: multi-channel PWM core behind a byte-addressed register file.
// Bytes arrive already deserialised. The first byte of a chip-select window sets
// the address pointer. Each later byte writes the register at the pointer and then
// increments the pointer. All channels share one period and one prescaler. PERIOD
// and DUTY are double-buffered and reach the counter only at a period boundary.
module pwm_channel_bank #(
  parameter int NumOfPWMOutputs = 4
) (
  input  logic                       CLK,
  input  logic                       _RST,
  input  logic                       _CS,
  input  logic                       RXValid,
  input  logic [7:0]                 RXByte,
  output logic [7:0]                 TXByte,
  output logic [NumOfPWMOutputs-1:0] PWMOutputs,
  output logic                       PeriodWrap
);

  localparam int N = NumOfPWMOutputs;

  typedef enum logic {
    ST_ADDR = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [7:0]   ptr_q, ptr_d;
  logic [1:0]   ctrl_q, ctrl_d;              // bit0 EN, bit1 INV
  logic [7:0]   period_pend_q, period_pend_d;
  logic [7:0]   period_act_q, period_act_d;
  logic [7:0]   prescale_q, prescale_d;
  logic [N-1:0] chen_q, chen_d;
  logic [7:0]   duty_pend_q [N];
  logic [7:0]   duty_pend_d [N];
  logic [7:0]   duty_act_q  [N];
  logic [7:0]   duty_act_d  [N];
  logic [7:0]   cnt_q, cnt_d;
  logic [7:0]   pcnt_q, pcnt_d;
  logic [7:0]   tx_q, tx_d;
  logic [N-1:0] pwm_q, pwm_d;
  logic         wrap_q, wrap_d;

  logic en, inv, tick, at_end;

  assign en     = ctrl_q[0];
  assign inv    = ctrl_q[1];
  assign tick   = (pcnt_q == prescale_q);
  assign at_end = (cnt_q == period_act_q);

  // Protocol FSM: the first byte loads the pointer, and each later byte writes a register.
  always_comb begin
    // NOTE: every signal driven here gets its hold value first, so no path can leave
    // a signal unassigned and infer a latch.
    state_d       = state_q;
    ptr_d         = ptr_q;
    ctrl_d        = ctrl_q;
    period_pend_d = period_pend_q;
    prescale_d    = prescale_q;
    chen_d        = chen_q;
    duty_pend_d   = duty_pend_q;
    if (RXValid && !_CS) begin
      if (state_q == ST_ADDR) begin
        ptr_d   = RXByte;
        state_d = ST_DATA;
      end else begin
        ptr_d = ptr_q + 8'd1;
        case (ptr_q)
          8'd0:    ctrl_d        = RXByte[1:0];
          8'd1:    period_pend_d = RXByte;
          8'd2:    prescale_d    = RXByte;
          8'd3:    chen_d        = RXByte[N-1:0];
          default: begin
            for (int i = 0; i < N; i++) begin
              if (ptr_q == 8'(4 + i)) duty_pend_d[i] = RXByte;
            end
          end
        endcase
      end
    end
    // A deasserted chip select always re-arms address capture, even after a byte
    // that was sampled on the same edge.
    if (_CS) state_d = ST_ADDR;
  end

  // Prescaler, period counter and shadow load at the wrap.
  always_comb begin
    cnt_d        = cnt_q;
    pcnt_d       = pcnt_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    wrap_d       = 1'b0;
    if (!en) begin
      cnt_d        = 8'd0;
      pcnt_d       = 8'd0;
      period_act_d = period_pend_q;
      duty_act_d   = duty_pend_q;
    end else if (tick) begin
      pcnt_d = 8'd0;
      if (at_end) begin
        cnt_d        = 8'd0;
        period_act_d = period_pend_q;
        duty_act_d   = duty_pend_q;
        wrap_d       = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      pcnt_d = pcnt_q + 8'd1;
    end
  end

  // Channel outputs and the readback byte, both registered on the next edge.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      pwm_d[i] = en & chen_q[i] & ((cnt_q < duty_act_q[i]) ^ inv);
    end
    tx_d = 8'h00;
    case (ptr_q)
      8'd0:    tx_d = {6'b0, ctrl_q};
      8'd1:    tx_d = period_pend_q;
      8'd2:    tx_d = prescale_q;
      8'd3:    tx_d = 8'(chen_q);
      default: begin
        for (int i = 0; i < N; i++) begin
          if (ptr_q == 8'(4 + i)) tx_d = duty_pend_q[i];
        end
      end
    endcase
  end

  // State register with synchronous reset. Reset takes priority over any incoming byte.
  always_ff @(posedge CLK) begin
    // NOTE: state updates use non-blocking assignments, so every flop samples the values
    // from before the edge, whatever the statement order.
    if (!_RST) begin
      state_q       <= ST_ADDR;
      ptr_q         <= 8'd0;
      ctrl_q        <= 2'b00;
      period_pend_q <= 8'hFF;
      period_act_q  <= 8'hFF;
      prescale_q    <= 8'd0;
      chen_q        <= {N{1'b1}};
      cnt_q         <= 8'd0;
      pcnt_q        <= 8'd0;
      tx_q          <= 8'h00;
      pwm_q         <= '0;
      wrap_q        <= 1'b0;
      // NOTE: the duty arrays hold only N bytes of flops and have defined reset values,
      // so they reset like any other register instead of being left uninitialised.
      for (int i = 0; i < N; i++) begin
        duty_pend_q[i] <= 8'd0;
        duty_act_q[i]  <= 8'd0;
      end
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      ctrl_q        <= ctrl_d;
      period_pend_q <= period_pend_d;
      period_act_q  <= period_act_d;
      prescale_q    <= prescale_d;
      chen_q        <= chen_d;
      cnt_q         <= cnt_d;
      pcnt_q        <= pcnt_d;
      tx_q          <= tx_d;
      pwm_q         <= pwm_d;
      wrap_q        <= wrap_d;
      duty_pend_q   <= duty_pend_d;
      duty_act_q    <= duty_act_d;
    end
  end

  assign TXByte     = tx_q;
  assign PWMOutputs = pwm_q;
  assign PeriodWrap = wrap_q;

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Self-checking bench for pwm_channel_bank (N = 4): register table, directed
// PWM/shadow/protocol sequences and randomized configurations checked against
// a cycle-indexed arithmetic model of the counter.
module tb_pwm_channel_bank;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cs_n;
  logic         rx_valid;
  logic [7:0]   rx_byte;
  logic [7:0]   tx_byte;
  logic [N-1:0] pwm;
  logic         wrap;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_channel_bank #(.NumOfPWMOutputs(N)) dut (
    .CLK        (clk),
    ._RST       (rst_n),
    ._CS        (cs_n),
    .RXValid    (rx_valid),
    .RXByte     (rx_byte),
    .TXByte     (tx_byte),
    .PWMOutputs (pwm),
    .PeriodWrap (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse-length monitor on channel 0
  bit mon_on = 1'b0;
  int run_len;
  int runs[$];
  always @(negedge clk) begin
    if (!mon_on) begin
      run_len <= 0;
      runs.delete();
    end else if (pwm[0]) begin
      run_len <= run_len + 1;
    end else if (run_len > 0) begin
      runs.push_back(run_len);
      run_len <= 0;
    end
  end

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [10];

  logic [7:0] mreg [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    cs_n = 1'b0;
    send_byte(a);
    send_byte(d);
    cs_n = 1'b1;
    step();
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
    cs_n = 1'b0;
    send_byte(a);
    step();
    d = tx_byte;
    cs_n = 1'b1;
    step();
  endtask

  task automatic wait_wrap(input string name, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!wrap && n < 200);
    if (!wrap) check({name, " timeout"}, 32'(wrap), 32'd1);
  endtask

  task automatic hold_check(input string name, input int cycles,
                            input logic [N-1:0] mask, input logic [N-1:0] val);
    int bad = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if ((pwm & mask) !== val) bad++;
    end
    check(name, bad, 0);
  endtask

  // Higher-level model of register writes: only mapped bits are stored.
  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'd0)                  mreg[a] = d & 8'h03;
    else if (a == 8'd3)             mreg[a] = d & 8'((1 << N) - 1);
    else if (a == 8'd1 || a == 8'd2) mreg[a] = d;
    else if (a >= 8'd4 && int'(a) < 4 + N) mreg[a] = d;
  endtask

  logic [7:0] rd;
  int n, hi0, wraps, other_bad;

  initial begin
    vecs[0] = '{8'h00, 8'hFE, 8'h02};
    vecs[1] = '{8'h01, 8'h37, 8'h37};
    vecs[2] = '{8'h02, 8'hA5, 8'hA5};
    vecs[3] = '{8'h03, 8'hF3, 8'h03};
    vecs[4] = '{8'h04, 8'h11, 8'h11};
    vecs[5] = '{8'h07, 8'h77, 8'h77};
    vecs[6] = '{8'h08, 8'h55, 8'h00};
    vecs[7] = '{8'h20, 8'h99, 8'h00};
    vecs[8] = '{8'hFF, 8'h12, 8'h00};
    vecs[9] = '{8'h00, 8'h00, 8'h00};

    // ---- Reset with a byte pending: reset must win ----
    rst_n = 1'b0; cs_n = 1'b0; rx_valid = 1'b1; rx_byte = 8'h01;
    step(); step();
    rst_n = 1'b1; rx_valid = 1'b0; cs_n = 1'b1;
    check("reset tx", tx_byte, 8'h00);
    check("reset pwm", pwm, 0);
    check("reset wrap", wrap, 0);
    step();
    check("reset ptr readback", tx_byte, 8'h00);
    read_reg(8'd0, rd); check("reset CTRL", rd, 8'h00);
    read_reg(8'd1, rd); check("reset PERIOD", rd, 8'hFF);
    read_reg(8'd2, rd); check("reset PRESCALE", rd, 8'h00);
    read_reg(8'd3, rd); check("reset CHEN", rd, 8'h0F);

    // ---- Register table ----
    foreach (vecs[i]) begin
      write_reg(vecs[i].addr, vecs[i].data);
      read_reg(vecs[i].addr, rd);
      check($sformatf("table[%0d] addr 0x%0h", i, vecs[i].addr), rd, vecs[i].exp);
    end
    write_reg(8'd4, 8'h00);
    write_reg(8'd7, 8'h00);

    // ---- Burst write with auto-increment ----
    cs_n = 1'b0;
    send_byte(8'h01); send_byte(8'h09); send_byte(8'h00);
    send_byte(8'h0F); send_byte(8'h05);
    send_byte(8'h07);                       // pointer is now 5 -> DUTY1
    cs_n = 1'b1; step();
    read_reg(8'd1, rd); check("burst PERIOD", rd, 8'h09);
    read_reg(8'd3, rd); check("burst CHEN", rd, 8'h0F);
    read_reg(8'd4, rd); check("burst DUTY0", rd, 8'h05);
    read_reg(8'd5, rd); check("burst ptr->DUTY1", rd, 8'h07);
    write_reg(8'd5, 8'h00);
    write_reg(8'd0, 8'h01);
    hi0 = 0; wraps = 0; other_bad = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (pwm[0]) hi0++;
      if (wrap) wraps++;
      if (pwm[N-1:1] != 0) other_bad++;
    end
    check("ch0 high cycles in 40", hi0, 20);
    check("wraps in 40", wraps, 4);
    check("other channels low", other_bad, 0);

    // ---- Shadowed duty update mid-period ----
    wait_wrap("shadow sync", n);
    mon_on = 1'b1;
    write_reg(8'd4, 8'h02);
    for (int c = 0; c < 27; c++) step();
    check("shadow run count", runs.size(), 3);
    if (runs.size() == 3) begin
      check("shadow run0 (old duty)", runs[0], 5);
      check("shadow run1 (new duty)", runs[1], 2);
      check("shadow run2 (new duty)", runs[2], 2);
    end
    mon_on = 1'b0;

    // ---- Extremes, invert, masking ----
    write_reg(8'd5, 8'h00);
    write_reg(8'd6, 8'hFF);
    wait_wrap("extremes sync", n);
    hold_check("duty0 low / duty255 high", 20, 4'b0110, 4'b0100);
    write_reg(8'd0, 8'h03);
    hold_check("inverted extremes", 20, 4'b0110, 4'b0010);
    write_reg(8'd3, 8'h0B);
    hold_check("masked ch2 / inverted ch3", 20, 4'b1100, 4'b1000);

    // ---- Prescaler ----
    cs_n = 1'b0;
    send_byte(8'h01); send_byte(8'h04); send_byte(8'h03);
    cs_n = 1'b1; step();
    wait_wrap("prescale sync", n);
    wait_wrap("prescale wrap1", n); check("prescale interval 1", n, 20);
    wait_wrap("prescale wrap2", n); check("prescale interval 2", n, 20);

    // ---- Protocol edges ----
    cs_n = 1'b1;
    send_byte(8'h00); send_byte(8'h00);
    read_reg(8'd0, rd); check("RXValid with CS high ignored", rd, 8'h03);
    cs_n = 1'b0;
    send_byte(8'hFF); send_byte(8'hAA); send_byte(8'h01);
    cs_n = 1'b1; step();
    read_reg(8'd0, rd); check("pointer wrap to CTRL", rd, 8'h01);
    read_reg(8'h20, rd); check("unmapped read", rd, 8'h00);
    cs_n = 1'b0;
    send_byte(8'h02);
    rx_valid = 1'b1; rx_byte = 8'h07;
    step();
    rx_valid = 1'b0; cs_n = 1'b1;           // CS rises right at the data edge
    step();
    read_reg(8'd2, rd); check("byte on CS rise processed", rd, 8'h07);

    // ---- Randomized configurations vs arithmetic model ----
    for (int t = 0; t < 12; t++) begin
      int per, ps, inv, len, c, cycles;
      logic [7:0] base, d, ctrlv;
      logic [N-1:0] exp_pwm;
      foreach (mreg[a]) mreg[a] = 8'h00;
      // full register image, CTRL first so the core is disabled
      cs_n = 1'b0;
      send_byte(8'h00);
      for (int a = 0; a < 4 + N; a++) begin
        d = 8'($urandom);
        if (a == 0) d = 8'h00;
        send_byte(d);
        model_write(8'(a), d);
      end
      cs_n = 1'b1; step();
      // noise with CS high, then random bursts (some crossing 0xFF)
      send_byte(8'($urandom));
      for (int b = 0; b < 4; b++) begin
        base = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255))
                                           : 8'($urandom_range(0, 10));
        len = $urandom_range(1, 4);
        cs_n = 1'b0;
        send_byte(base);
        for (int k = 0; k < len; k++) begin
          d = 8'($urandom);
          send_byte(d);
          model_write(base + 8'(k), d);
        end
        cs_n = 1'b1; step();
      end
      for (int a = 0; a <= 4 + N; a++) begin
        read_reg(8'(a), rd);
        check($sformatf("rand[%0d] readback 0x%0h", t, a), rd, mreg[a]);
      end
      base = 8'($urandom_range(4 + N, 255));
      read_reg(base, rd);
      check($sformatf("rand[%0d] unmapped 0x%0h", t, base), rd, 8'h00);

      // small timing config, duties spanning 0 .. beyond PERIOD
      per = $urandom_range(0, 12);
      ps  = $urandom_range(0, 3);
      inv = $urandom_range(0, 1);
      cs_n = 1'b0;
      send_byte(8'h00);
      send_byte(8'h00);                      // disable while reloading
      send_byte(8'(per)); model_write(8'd1, 8'(per));
      send_byte(8'(ps));  model_write(8'd2, 8'(ps));
      d = 8'($urandom); send_byte(d); model_write(8'd3, d);
      for (int i = 0; i < N; i++) begin
        d = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(0, per + 2));
        send_byte(d);
        model_write(8'(4 + i), d);
      end
      cs_n = 1'b1; step();
      ctrlv = 8'(1 | (inv << 1) | ($urandom_range(0, 63) << 2));
      cs_n = 1'b0;
      send_byte(8'h00);
      send_byte(ctrlv);                      // enabling edge: j = 0
      cs_n = 1'b1;
      cycles = 2 * (ps + 1) * (per + 1) + 3;
      for (int j = 1; j <= cycles; j++) begin
        step();
        c = ((j - 1) / (ps + 1)) % (per + 1);
        for (int i = 0; i < N; i++)
          exp_pwm[i] = mreg[3][i] & ((c < int'(mreg[4 + i])) ^ inv[0]);
        check($sformatf("rand[%0d] pwm j=%0d", t, j), pwm, exp_pwm);
        check($sformatf("rand[%0d] wrap j=%0d", t, j), wrap,
              32'((j % ((ps + 1) * (per + 1))) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
